// File: rtl/round_key_reader.sv
// Reads AES expanded-key words back from the key RAM and presents them as
// 128-bit round keys, forward (encrypt) or reverse (decrypt) order.
module round_key_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic                dir,
  input  logic [1:0]          key_len,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [4*DATA_W-1:0] round_key,
  output logic [3:0]          round_idx,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                rk_last,
  output logic                busy,
  output logic                done,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic                dir_q;
  logic [3:0]          nr_q;
  logic [3:0]          r_q;
  logic [1:0]          k_q;
  logic [4*DATA_W-1:0] key_q;
  logic [3:0]          nr_sel;
  logic                last_key;
  logic                xfer;
  logic                cap_en;
  logic [1:0]          slot;

  // Handshake: round_key/round_idx/rk_last are stable while rk_valid is high;
  // a key moves on any edge where rk_valid & rk_ready, and rk_valid then drops.
  assign xfer     = (state == PRESENT) && rk_ready;
  assign last_key = dir_q ? (r_q == 4'd0) : (r_q == nr_q);

  always_comb begin
    nr_sel = 4'd10;
    case (key_len)
      2'd1:    nr_sel = 4'd12;
      2'd2:    nr_sel = 4'd14;
      default: nr_sel = 4'd10;
    endcase
  end

  // RAM data lags rd_en by one cycle, so FETCH k fills slot k-1 and DRAIN slot 3.
  always_comb begin
    cap_en = 1'b0;
    slot   = 2'd0;
    if (state == FETCH && k_q != 2'd0) begin
      cap_en = 1'b1;
      slot   = k_q - 2'd1;
    end else if (state == DRAIN) begin
      cap_en = 1'b1;
      slot   = 2'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      dir_q <= 1'b0;
      nr_q  <= 4'd0;
      r_q   <= 4'd0;
      k_q   <= 2'd0;
      key_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q <= dir;
            nr_q  <= nr_sel;
            r_q   <= dir ? nr_sel : 4'd0;
            k_q   <= 2'd0;
          end
        end
        FETCH: k_q <= k_q + 2'd1;
        PRESENT: begin
          if (xfer && !last_key) begin
            r_q <= dir_q ? (r_q - 4'd1) : (r_q + 4'd1);
            k_q <= 2'd0;
          end
        end
        default: ;
      endcase
      if (cap_en) begin
        key_q[(2'd3 - slot)*DATA_W +: DATA_W] <= rd_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (k_q == 2'd3) state_nxt = DRAIN;
      DRAIN:   state_nxt = PRESENT;
      PRESENT: if (xfer) state_nxt = last_key ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    rk_valid  = 1'b0;
    rk_last   = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    fsm_state = state;
    round_key = key_q;
    round_idx = r_q;
    case (state)
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = ADDR_W'({r_q, k_q});
      end
      PRESENT: begin
        rk_valid = 1'b1;
        rk_last  = last_key;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_round_key_reader.sv
// Bench for round_key_reader: a RAM model, a queue-based expected key schedule
// built from the word layout, directed corner sequences and a vector table.
module tb_round_key_reader;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic         rk_ready = 1'b0;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [31:0]  rd_data;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         rk_last;
  logic         busy;
  logic         done;
  logic [2:0]   fsm_state;

  logic [31:0]  mem [64];
  logic [127:0] exp_key_q [$];
  logic [3:0]   exp_idx_q [$];
  logic [5:0]   exp_addr_q [$];
  int           tests = 0;
  int           fails = 0;

  typedef struct {
    logic       d;
    logic [1:0] kl;
    int         pct;
    int         exp_n;
    int         exp_first;
  } vec_t;
  vec_t vecs [8];

  round_key_reader #(.ADDR_W(6), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .dir(dir), .key_len(key_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .round_key(round_key), .round_idx(round_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  // clock and RAM model (one-cycle read latency)
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input bit pattern);
    for (int i = 0; i < 64; i++) mem[i] = pattern ? (32'h1000_0000 + 32'(i)) : $urandom;
  endtask

  // Expected schedule: key r is words 4r..4r+3, visited 0..Nr or Nr..0.
  task automatic build_expected(input logic d, input logic [1:0] kl);
    int nr;
    int r;
    exp_key_q.delete();
    exp_idx_q.delete();
    exp_addr_q.delete();
    nr = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    for (int i = 0; i <= nr; i++) begin
      r = d ? nr - i : i;
      exp_key_q.push_back({mem[4*r], mem[4*r+1], mem[4*r+2], mem[4*r+3]});
      exp_idx_q.push_back(4'(r));
      for (int k = 0; k < 4; k++) exp_addr_q.push_back(6'(4*r + k));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, 128'(rd_en), '0);
    chk({tag, "_rd_addr"}, 128'(rd_addr), '0);
    chk({tag, "_round_key"}, round_key, '0);
    chk({tag, "_round_idx"}, 128'(round_idx), '0);
    chk({tag, "_rk_valid"}, 128'(rk_valid), '0);
    chk({tag, "_rk_last"}, 128'(rk_last), '0);
    chk({tag, "_busy"}, 128'(busy), '0);
    chk({tag, "_done"}, 128'(done), '0);
    chk({tag, "_state"}, 128'(fsm_state), '0);
  endtask

  task automatic run_seq(input logic d, input logic [1:0] kl, input int pct,
                         input int stall_idx, input int stall_len, input int inject_cyc,
                         input int abort_idx, output int n_xfer,
                         output logic [127:0] first_key, output int first_idx);
    int           cyc, first_valid, last_xfer, stall_left, done_cnt, end_cyc;
    bit           waiting, finished;
    logic [127:0] held_key;
    logic [3:0]   held_idx;
    logic         exp_last;
    build_expected(d, kl);
    n_xfer = 0; first_key = '0; first_idx = -1; first_valid = -1; last_xfer = -1;
    stall_left = stall_len; done_cnt = 0; end_cyc = -1; waiting = 0; finished = 0;
    held_key = '0; held_idx = '0;
    @(negedge Clk);
    start = 1'b1; dir = d; key_len = kl;
    @(negedge Clk);
    start = 1'b0; dir = 1'($urandom); key_len = 2'($urandom);
    cyc = 1;
    while (!finished && cyc < 3000) begin
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) dir = 1'b1;
      if (rk_valid && stall_left > 0 && int'(round_idx) == stall_idx) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = (int'($urandom_range(0, 99)) < pct);
      end
      if (end_cyc < 0) chk("busy_high", 128'(busy), 128'(1));
      if (rd_en) begin
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_extra: got read of %0d expected no read", rd_addr);
        end else chk("rd_addr", 128'(rd_addr), 128'(exp_addr_q.pop_front()));
      end
      if (rk_valid) begin
        chk("rd_en_while_valid", 128'(rd_en), '0);
        if (waiting) begin
          chk("hold_key", round_key, held_key);
          chk("hold_idx", 128'(round_idx), 128'(held_idx));
        end else if (first_valid < 0) begin
          first_valid = cyc; first_key = round_key; first_idx = int'(round_idx);
          chk("first_latency", 128'(cyc), 128'(6));
        end else chk("refetch_gap", 128'(cyc - last_xfer), 128'(6));
        if (abort_idx >= 0 && int'(round_idx) == abort_idx) begin
          rk_ready = 1'b0; Rst = 1'b0;
          @(negedge Clk);
          Rst = 1'b1;
          check_zero("abort");
          repeat (6) begin
            @(negedge Clk);
            chk("abort_no_done", 128'(done), '0);
            chk("abort_no_read", 128'(rd_en), '0);
          end
          finished = 1;
        end else if (rk_ready) begin
          exp_last = (exp_key_q.size() == 1);
          if (exp_key_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_key: got idx %0d expected no key", round_idx);
          end else begin
            chk("key", round_key, exp_key_q.pop_front());
            chk("idx", 128'(round_idx), 128'(exp_idx_q.pop_front()));
            chk("last", 128'(rk_last), 128'(exp_last));
          end
          n_xfer++; last_xfer = cyc; waiting = 0;
        end else begin
          waiting = 1; held_key = round_key; held_idx = round_idx;
        end
      end else if (!finished) begin
        chk("last_low_when_invalid", 128'(rk_last), '0);
      end
      if (!finished) begin
        if (done) begin
          done_cnt++;
          chk("done_after_last", 128'(exp_key_q.size()), '0);
          if (end_cyc < 0) end_cyc = cyc;
        end
        if (end_cyc >= 0 && cyc == end_cyc + 1) begin
          chk("busy_drop", 128'(busy), '0);
          chk("idle_state", 128'(fsm_state), '0);
        end
        if (end_cyc >= 0 && cyc == end_cyc + 3) finished = 1;
      end
      if (!finished) begin
        @(negedge Clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!finished) begin
      tests++; fails++;
      $display("FAIL timeout: got no completion expected done within 3000 cycles");
    end
    if (abort_idx < 0) chk("done_once", 128'(done_cnt), 128'(1));
    if (stall_len > 0) chk("stall_applied", 128'(stall_left), '0);
  endtask

  initial begin
    int           n;
    int           fi;
    logic [127:0] fk;
    vecs[0] = '{d: 1'b0, kl: 2'd0, pct: 60, exp_n: 11, exp_first: 0};
    vecs[1] = '{d: 1'b0, kl: 2'd1, pct: 70, exp_n: 13, exp_first: 0};
    vecs[2] = '{d: 1'b0, kl: 2'd2, pct: 50, exp_n: 15, exp_first: 0};
    vecs[3] = '{d: 1'b0, kl: 2'd3, pct: 80, exp_n: 11, exp_first: 0};
    vecs[4] = '{d: 1'b1, kl: 2'd0, pct: 60, exp_n: 11, exp_first: 10};
    vecs[5] = '{d: 1'b1, kl: 2'd1, pct: 75, exp_n: 13, exp_first: 12};
    vecs[6] = '{d: 1'b1, kl: 2'd2, pct: 40, exp_n: 15, exp_first: 14};
    vecs[7] = '{d: 1'b1, kl: 2'd3, pct: 90, exp_n: 11, exp_first: 10};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_zero("reset");
    Rst = 1'b1;

    fill_mem(1'b1);
    run_seq(1'b0, 2'd0, 100, -1, 0, -1, -1, n, fk, fi);
    chk("fwd128_key0", fk, 128'h10000000_10000001_10000002_10000003);
    chk("fwd128_count", 128'(n), 128'(11));
    chk("fwd128_first_idx", 128'(fi), 128'(0));

    fill_mem(1'b0);
    run_seq(1'b1, 2'd2, 100, -1, 0, -1, -1, n, fk, fi);
    chk("rev256_count", 128'(n), 128'(15));
    chk("rev256_first_idx", 128'(fi), 128'(14));

    fill_mem(1'b0);
    run_seq(1'b0, 2'd1, 100, 5, 20, -1, -1, n, fk, fi);
    chk("stall192_count", 128'(n), 128'(13));

    fill_mem(1'b0);
    run_seq(1'b0, 2'd0, 100, -1, 0, 2, -1, n, fk, fi);
    chk("ignore_start_count", 128'(n), 128'(11));

    fill_mem(1'b0);
    run_seq(1'b0, 2'd0, 100, -1, 0, -1, 3, n, fk, fi);
    chk("abort_count", 128'(n), 128'(3));
    run_seq(1'b0, 2'd0, 100, -1, 0, -1, -1, n, fk, fi);
    chk("after_abort_count", 128'(n), 128'(11));
    chk("after_abort_first_idx", 128'(fi), 128'(0));

    for (int i = 0; i < 8; i++) begin
      fill_mem(1'b0);
      run_seq(vecs[i].d, vecs[i].kl, vecs[i].pct, -1, 0, -1, -1, n, fk, fi);
      chk("vec_count", 128'(n), 128'(vecs[i].exp_n));
      chk("vec_first_idx", 128'(fi), 128'(vecs[i].exp_first));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
